// File: rtl/m10k_arb_pkg.sv
// Shared types and constants for the M10K read-port arbiter.
package m10k_arb_pkg;

    // Registered M10K read: address flop plus output flop.
    localparam int unsigned RD_LATENCY = 2;

    // Largest supported requester count; sizes the tag index field.
    localparam int unsigned MAX_NUM_RD = 8;

    // Index width that stays at least 1 bit even for a single requester.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned IDXW = idx_width(MAX_NUM_RD);

    // One stage of the read-return tag pipeline.
    typedef struct packed {
        logic            vld;
        logic [IDXW-1:0] idx;
    } rd_tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one grant per cycle among eligible requesters, search
// starting at the pointer; the pointer moves past the winner.
module rr_arbiter
    import m10k_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned IdxW   = idx_width(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] mask,
    output logic [NUM_REQ-1:0] gnt,
    output logic               gnt_any,
    output logic [IdxW-1:0]    gnt_idx
);

    logic [IdxW-1:0]    ptr_q, ptr_d;
    logic [NUM_REQ-1:0] elig;

    // Rotating search for the first eligible requester from the pointer.
    always_comb begin
        int unsigned cand;
        cand    = 0;
        elig    = req & mask;
        gnt     = '0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = 32'(ptr_q) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!gnt_any && elig[cand]) begin
                gnt[cand] = 1'b1;
                gnt_any   = 1'b1;
                gnt_idx   = IdxW'(cand);
            end
        end
    end

    // Pointer advances past the winner; unchanged when nothing is granted.
    always_comb begin
        ptr_d = ptr_q;
        if (gnt_any) begin
            if (gnt_idx == IdxW'(NUM_REQ - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = gnt_idx + IdxW'(1);
            end
        end
    end

    // Pointer register, synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/m10k_rd_arbiter.sv
// Shares one M10K between NUM_RD read requesters and a single writer.
// Read data returns on the shared bus RD_LATENCY cycles after the grant,
// tagged by a one-hot rd_vld.
module m10k_rd_arbiter
    import m10k_arb_pkg::*;
#(
    parameter int unsigned NUM_RD     = 4,
    parameter int unsigned DATA_WIDTH = 10,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned ITE_NUM    = 100
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wr_valid,
    input  logic [ADDR_WIDTH-1:0]        wr_addr,
    input  logic [DATA_WIDTH-1:0]        wr_data,
    input  logic [NUM_RD-1:0]            rd_req,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_RD-1:0]            rd_gnt,
    output logic [NUM_RD-1:0]            rd_vld,
    output logic [DATA_WIDTH-1:0]        rd_data,
    output logic                         addr_err,
    output logic                         mem_we,
    output logic [ADDR_WIDTH-1:0]        mem_waddr,
    output logic [DATA_WIDTH-1:0]        mem_d,
    output logic [ADDR_WIDTH-1:0]        mem_raddr,
    input  logic [DATA_WIDTH-1:0]        mem_q
);

    localparam int unsigned IdxW = idx_width(NUM_RD);
    localparam logic [ADDR_WIDTH:0] AddrLimit = (ADDR_WIDTH + 1)'(ITE_NUM);

    logic [ADDR_WIDTH-1:0] req_addr [NUM_RD];
    logic [NUM_RD-1:0]     hazard;
    logic [NUM_RD-1:0]     elig_mask;
    logic [NUM_RD-1:0]     gnt;
    logic                  gnt_any;
    logic [IdxW-1:0]       gnt_idx;
    logic [ADDR_WIDTH-1:0] gnt_addr;

    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
    rd_tag_t               tag_q [RD_LATENCY];
    rd_tag_t               tag_d [RD_LATENCY];
    logic                  addr_err_q, addr_err_d;

    // Unpack addresses and skip any requester colliding with this cycle's write,
    // since the RAM does not resolve same-address read/write.
    always_comb begin
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            req_addr[i] = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            hazard[i]   = wr_valid && (req_addr[i] == wr_addr);
        end
        elig_mask = ~hazard & {NUM_RD{~reset}};
    end

    rr_arbiter #(
        .NUM_REQ (NUM_RD)
    ) u_rr_arbiter (
        .clk     (clk),
        .reset   (reset),
        .req     (rd_req),
        .mask    (elig_mask),
        .gnt     (gnt),
        .gnt_any (gnt_any),
        .gnt_idx (gnt_idx)
    );

    // Read address mux; hold the last granted address while idle.
    always_comb begin
        gnt_addr = req_addr[gnt_idx];
        raddr_d  = gnt_any ? gnt_addr : raddr_q;
    end

    // Tag pipeline next state: stage 0 captures the grant, later stages shift.
    always_comb begin
        tag_d[0].vld = gnt_any;
        tag_d[0].idx = IDXW'(gnt_idx);
        for (int unsigned k = 1; k < RD_LATENCY; k++) begin
            tag_d[k] = tag_q[k-1];
        end
    end

    // Sticky out-of-range flag for granted reads and accepted writes.
    always_comb begin
        addr_err_d = addr_err_q;
        if (gnt_any && ({1'b0, gnt_addr} >= AddrLimit)) begin
            addr_err_d = 1'b1;
        end
        if (wr_valid && ({1'b0, wr_addr} >= AddrLimit)) begin
            addr_err_d = 1'b1;
        end
    end

    // Outputs; reset masks grant, return strobe and write enable immediately.
    always_comb begin
        rd_gnt    = gnt;
        rd_vld    = '0;
        if (tag_q[RD_LATENCY-1].vld && !reset) begin
            rd_vld[tag_q[RD_LATENCY-1].idx[IdxW-1:0]] = 1'b1;
        end
        rd_data   = mem_q;
        addr_err  = addr_err_q;
        mem_we    = wr_valid & ~reset;
        mem_waddr = wr_addr;
        mem_d     = wr_data;
        mem_raddr = raddr_d;
    end

    // State registers; reset drops all in-flight reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            raddr_q    <= '0;
            addr_err_q <= 1'b0;
            for (int unsigned k = 0; k < RD_LATENCY; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            raddr_q    <= raddr_d;
            addr_err_q <= addr_err_d;
            for (int unsigned k = 0; k < RD_LATENCY; k++) begin
                tag_q[k] <= tag_d[k];
            end
        end
    end

endmodule

// File: tb/tb_m10k_rd_arbiter.sv
// Self-checking bench: M10K model behind the arbiter, reference arbitration
// model and a return-data scoreboard, plus directed scenario checks.
module tb_m10k_rd_arbiter;

    localparam int NRD = 4;
    localparam int DW  = 10;
    localparam int AW  = 10;
    localparam int ITE = 100;

    logic              clk = 1'b0;
    logic              reset;
    logic              wr_valid;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic [NRD-1:0]    rd_req;
    logic [NRD*AW-1:0] rd_addr;
    logic [NRD-1:0]    rd_gnt;
    logic [NRD-1:0]    rd_vld;
    logic [DW-1:0]     rd_data;
    logic              addr_err;
    logic              mem_we;
    logic [AW-1:0]     mem_waddr;
    logic [DW-1:0]     mem_d;
    logic [AW-1:0]     mem_raddr;
    logic [DW-1:0]     mem_q;

    m10k_rd_arbiter #(
        .NUM_RD     (NRD),
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .ITE_NUM    (ITE)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_valid  (wr_valid),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_gnt    (rd_gnt),
        .rd_vld    (rd_vld),
        .rd_data   (rd_data),
        .addr_err  (addr_err),
        .mem_we    (mem_we),
        .mem_waddr (mem_waddr),
        .mem_d     (mem_d),
        .mem_raddr (mem_raddr),
        .mem_q     (mem_q)
    );

    always #5 clk = ~clk;

    // M10K model: registered address, registered output.
    logic [DW-1:0] ram [1024];
    logic [AW-1:0] ram_raddr_q;
    always @(posedge clk) begin
        if (mem_we) ram[mem_waddr] <= mem_d;
        ram_raddr_q <= mem_raddr;
        mem_q       <= ram[ram_raddr_q];
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model state.
    typedef struct {
        int            due;
        int            idx;
        logic [DW-1:0] data;
    } sb_t;
    sb_t           sb [$];
    logic [DW-1:0] mmem [1024];
    int            cyc = 0;
    int            mdl_ptr = 0;
    logic          err_m = 1'b0;
    logic [AW-1:0] last_raddr_m = '0;
    logic [NRD-1:0] mdl_gnt = '0;

    // Monitor at the falling edge: model arbitration, scoreboard, sticky error.
    always @(negedge clk) begin
        int            g;
        int            ci;
        logic [AW-1:0] ga;
        sb_t           e;
        cyc++;
        if (reset) begin
            check_eq("rst_gnt", 32'(rd_gnt), 32'(0));
            check_eq("rst_vld", 32'(rd_vld), 32'(0));
            check_eq("rst_we", 32'(mem_we), 32'(0));
            sb.delete();
            mdl_ptr      = 0;
            err_m        = 1'b0;
            last_raddr_m = '0;
            mdl_gnt      = '0;
        end else begin
            check_eq("addr_err", 32'(addr_err), 32'(err_m));
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                check_eq("vld_route", 32'(rd_vld), 32'(1) << e.idx);
                check_eq("rd_data", 32'(rd_data), 32'(e.data));
            end else begin
                check_eq("vld_idle", 32'(rd_vld), 32'(0));
            end
            g = -1;
            for (int k = 0; k < NRD; k++) begin
                ci = (mdl_ptr + k) % NRD;
                if (g < 0 && rd_req[ci] && !(wr_valid && rd_addr[ci*AW +: AW] == wr_addr))
                    g = ci;
            end
            mdl_gnt = (g >= 0) ? NRD'(1) << g : '0;
            check_eq("gnt", 32'(rd_gnt), 32'(mdl_gnt));
            check_eq("mem_we", 32'(mem_we), 32'(wr_valid));
            if (g >= 0) begin
                ga = rd_addr[g*AW +: AW];
                check_eq("raddr", 32'(mem_raddr), 32'(ga));
                e.due  = cyc + 2;
                e.idx  = g;
                e.data = mmem[ga];
                sb.push_back(e);
                mdl_ptr      = (g + 1) % NRD;
                last_raddr_m = ga;
                if (ga >= AW'(ITE)) err_m = 1'b1;
            end else begin
                check_eq("raddr_hold", 32'(mem_raddr), 32'(last_raddr_m));
            end
            if (wr_valid) begin
                if (wr_addr >= AW'(ITE)) err_m = 1'b1;
                mmem[wr_addr] = wr_data;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int i, input int a);
        rd_addr[i*AW +: AW] = AW'(a);
    endtask

    logic [NRD-1:0] pend;

    initial begin
        for (int i = 0; i < 1024; i++) begin
            ram[i]  = '0;
            mmem[i] = '0;
        end
        mem_q = '0;
        reset = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        rd_req = '0; rd_addr = '0;
        #1;
        tick(); tick();
        reset = 1'b0;

        // Preload words 10..13.
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1; wr_addr = AW'(10 + i); wr_data = DW'(16 + i);
            tick();
        end
        wr_valid = 1'b0;

        // All four requesting: strict rotation.
        rd_req = 4'b1111;
        for (int i = 0; i < 4; i++) set_addr(i, 10 + i);
        for (int k = 0; k < 8; k++) begin
            #2 check_eq("rr_order", 32'(rd_gnt), 32'(1) << (k % 4));
            tick();
        end
        rd_req = '0;
        tick(); tick(); tick();

        // Single requester: granted every cycle.
        rd_req = 4'b0100; set_addr(2, 5);
        for (int k = 0; k < 6; k++) begin
            #2 check_eq("single", 32'(rd_gnt), 32'h4);
            tick();
        end
        rd_req = '0;
        tick(); tick(); tick();

        // Read/write hazard on address 7.
        wr_valid = 1'b1; wr_addr = 7; wr_data = 10'h2A;
        rd_req = 4'b0001; set_addr(0, 7);
        #2 check_eq("haz_block", 32'(rd_gnt), 32'(0));
        tick();
        wr_valid = 1'b0;
        #2 check_eq("haz_gnt", 32'(rd_gnt), 32'h1);
        tick();
        rd_req = '0;
        tick();
        #2 check_eq("haz_vld", 32'(rd_vld), 32'h1);
        check_eq("haz_data", 32'(rd_data), 32'h2A);
        tick(); tick();

        // Reset with reads in flight.
        rd_req = 4'b0011; set_addr(0, 10); set_addr(1, 11);
        tick();
        rd_req = 4'b0001;
        tick();
        rd_req = '0; reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #2 check_eq("rst_drop", 32'(rd_vld), 32'(0));
            tick();
        end
        rd_req = 4'b1111;
        for (int i = 0; i < 4; i++) set_addr(i, 10 + i);
        #2 check_eq("rst_ptr", 32'(rd_gnt), 32'h1);
        tick();
        rd_req = '0;
        tick(); tick(); tick();

        // Out-of-range read sets sticky error.
        #2 check_eq("err_clear", 32'(addr_err), 32'(0));
        rd_req = 4'b0001; set_addr(0, 120);
        tick();
        rd_req = '0; set_addr(0, 0);
        for (int k = 0; k < 5; k++) begin
            #2 check_eq("err_sticky", 32'(addr_err), 32'(1));
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #2 check_eq("err_rst", 32'(addr_err), 32'(0));
        tick();

        // Random traffic against the model.
        pend = '0;
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < NRD; i++) begin
                if (mdl_gnt[i]) pend[i] = 1'b0;
                if (!pend[i] && ($urandom % 3 == 0)) begin
                    pend[i] = 1'b1;
                    set_addr(i, (($urandom % 4) == 0) ? int'($urandom_range(0, ITE - 1))
                                                      : int'($urandom_range(0, 15)));
                end
            end
            rd_req   = pend;
            wr_valid = ($urandom % 3 == 0);
            wr_addr  = AW'($urandom_range(0, 15));
            wr_data  = DW'($urandom);
            tick();
        end
        rd_req = '0; wr_valid = 1'b0;
        tick(); tick(); tick(); tick();
        check_eq("drain", 32'(sb.size()), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
